// File: rtl/lsu_mem_stage.sv
// Load/store stage between EX and WB: issues B/H/W(/D) accesses over req/gnt/rvalid.
// Latency: non-memory and misaligned ops retire next cycle; aligned memory ops retire >=3 cycles after accept.
// Backpressure: lsu_stall holds EX while an access is outstanding; released in the rvalid or abort cycle.
//
// Ports: clk/reset (sync, active-high); ex_* instruction from EX; lsu_stall back to EX;
// mem_req/we/adr/wdata/be out and mem_gnt/rvalid/err/rdata in for data memory;
// lsu_valid/data/rslt/rd_adr/opcode/PC/exc/exc_cause registered toward WB.
module lsu_mem_stage #(
    parameter int REG_WIDTH = 32,
    parameter int PC_WIDTH  = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ex_valid,
    input  logic [6:0]             ex_opcode,
    input  logic [2:0]             ex_funct3,
    input  logic [REG_WIDTH-1:0]   ex_rslt,
    input  logic [REG_WIDTH-1:0]   ex_rs2,
    input  logic [4:0]             ex_rd_adr,
    input  logic [PC_WIDTH-1:0]    ex_PC,
    output logic                   lsu_stall,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [PC_WIDTH-1:0]    mem_adr,
    output logic [REG_WIDTH-1:0]   mem_wdata,
    output logic [REG_WIDTH/8-1:0] mem_be,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic                   mem_err,
    input  logic [REG_WIDTH-1:0]   mem_rdata,
    output logic                   lsu_valid,
    output logic [REG_WIDTH-1:0]   lsu_data,
    output logic [REG_WIDTH-1:0]   lsu_rslt,
    output logic [4:0]             lsu_rd_adr,
    output logic [6:0]             lsu_opcode,
    output logic [PC_WIDTH-1:0]    lsu_PC,
    output logic                   lsu_exc,
    output logic [1:0]             lsu_exc_cause
);
    localparam int NB = REG_WIDTH / 8;
    localparam int LW = $clog2(NB);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    // Returns {sign_extend, log2(bytes)}; unknown codes fall back to a signed word.
    function automatic logic [2:0] dec_size(input logic [2:0] f3);
        case (f3)
            3'b000:  return 3'b100;
            3'b001:  return 3'b101;
            3'b010:  return 3'b110;
            3'b100:  return 3'b000;
            3'b101:  return 3'b001;
            3'b011:  return (REG_WIDTH == 64) ? 3'b011 : 3'b110;
            3'b110:  return (REG_WIDTH == 64) ? 3'b010 : 3'b110;
            default: return 3'b110;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [6:0]             op_q, op_d;
    logic [2:0]             f3_q, f3_d;
    logic [REG_WIDTH-1:0]   adr_q, adr_d;
    logic [REG_WIDTH-1:0]   rs2_q, rs2_d;
    logic [4:0]             rd_q, rd_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;

    logic                   lsu_valid_q, lsu_valid_d;
    logic [REG_WIDTH-1:0]   lsu_data_q, lsu_data_d;
    logic [REG_WIDTH-1:0]   lsu_rslt_q, lsu_rslt_d;
    logic [4:0]             lsu_rd_adr_q, lsu_rd_adr_d;
    logic [6:0]             lsu_opcode_q, lsu_opcode_d;
    logic [PC_WIDTH-1:0]    lsu_PC_q, lsu_PC_d;
    logic                   lsu_exc_q, lsu_exc_d;
    logic [1:0]             lsu_exc_cause_q, lsu_exc_cause_d;

    logic [2:0]             ex_dec, hold_dec;
    logic                   ex_mem, ex_aligned, timeout;
    logic                   retire_hold, hold_fault;
    logic [LW-1:0]          lane;
    logic [NB-1:0]          size_mask;
    logic [REG_WIDTH-1:0]   ld_mask, rd_shift, ld_data;
    logic                   ld_sign;

    assign ex_dec     = dec_size(ex_funct3);
    assign hold_dec   = dec_size(f3_q);
    assign ex_mem     = (ex_opcode == OP_LOAD) || (ex_opcode == OP_STORE);
    assign ex_aligned = (ex_rslt[2:0] & 3'((1 << ex_dec[1:0]) - 1)) == 3'd0;
    assign timeout    = (timer_q == TW'(TIMEOUT - 1));
    assign lane       = adr_q[LW-1:0];

    // Access-size masks for the held op: per byte for mem_be, per bit for load extraction.
    always_comb begin
        size_mask = '0;
        ld_mask   = '0;
        for (int i = 0; i < NB; i++) begin
            size_mask[i]      = (i < (1 << hold_dec[1:0]));
            ld_mask[8*i +: 8] = {8{size_mask[i]}};
        end
    end

    // Bring the addressed lane down to bit 0; the top bit of ld_mask selects the sign bit.
    assign rd_shift = mem_rdata >> {lane, 3'b000};
    assign ld_sign  = hold_dec[2] & (|(rd_shift & ld_mask & ~(ld_mask >> 1)));
    assign ld_data  = (rd_shift & ld_mask) | (ld_sign ? ~ld_mask : '0);

    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = (op_q == OP_STORE);
    assign mem_adr   = PC_WIDTH'(adr_q);
    assign mem_be    = size_mask << lane;
    assign mem_wdata = rs2_q << {lane, 3'b000};

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        op_d            = op_q;
        f3_d            = f3_q;
        adr_d           = adr_q;
        rs2_d           = rs2_q;
        rd_d            = rd_q;
        pc_d            = pc_q;
        lsu_valid_d     = 1'b0;
        lsu_data_d      = lsu_data_q;
        lsu_rslt_d      = lsu_rslt_q;
        lsu_rd_adr_d    = lsu_rd_adr_q;
        lsu_opcode_d    = lsu_opcode_q;
        lsu_PC_d        = lsu_PC_q;
        lsu_exc_d       = lsu_exc_q;
        lsu_exc_cause_d = lsu_exc_cause_q;
        lsu_stall       = 1'b0;
        retire_hold     = 1'b0;
        hold_fault      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    if (ex_mem && ex_aligned) begin
                        op_d      = ex_opcode;
                        f3_d      = ex_funct3;
                        adr_d     = ex_rslt;
                        rs2_d     = ex_rs2;
                        rd_d      = ex_rd_adr;
                        pc_d      = ex_PC;
                        timer_d   = '0;
                        state_d   = S_REQ;
                        lsu_stall = 1'b1;
                    end else begin
                        // ALU op passes through; a misaligned memop retires with an exception.
                        lsu_valid_d     = 1'b1;
                        lsu_data_d      = '0;
                        lsu_rslt_d      = ex_rslt;
                        lsu_rd_adr_d    = ex_rd_adr;
                        lsu_opcode_d    = ex_opcode;
                        lsu_PC_d        = ex_PC;
                        lsu_exc_d       = ex_mem;
                        lsu_exc_cause_d = {1'b0, ex_opcode == OP_STORE};
                    end
                end
            end
            S_REQ: begin
                timer_d = timer_q + 1'b1;
                if (timeout) begin
                    retire_hold = 1'b1;
                    hold_fault  = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    lsu_stall = 1'b1;
                    if (mem_gnt) state_d = S_RESP;
                end
            end
            S_RESP: begin
                timer_d = timer_q + 1'b1;
                if (mem_rvalid) begin
                    retire_hold = 1'b1;
                    hold_fault  = mem_err;
                    state_d     = S_IDLE;
                end else if (timeout) begin
                    retire_hold = 1'b1;
                    hold_fault  = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    lsu_stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (retire_hold) begin
            lsu_valid_d     = 1'b1;
            lsu_rslt_d      = adr_q;
            lsu_rd_adr_d    = rd_q;
            lsu_opcode_d    = op_q;
            lsu_PC_d        = pc_q;
            lsu_exc_d       = hold_fault;
            lsu_exc_cause_d = {1'b1, op_q == OP_STORE};
            lsu_data_d      = (!hold_fault && op_q == OP_LOAD) ? ld_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            timer_q         <= '0;
            op_q            <= '0;
            f3_q            <= '0;
            adr_q           <= '0;
            rs2_q           <= '0;
            rd_q            <= '0;
            pc_q            <= '0;
            lsu_valid_q     <= 1'b0;
            lsu_data_q      <= '0;
            lsu_rslt_q      <= '0;
            lsu_rd_adr_q    <= '0;
            lsu_opcode_q    <= '0;
            lsu_PC_q        <= '0;
            lsu_exc_q       <= 1'b0;
            lsu_exc_cause_q <= '0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            op_q            <= op_d;
            f3_q            <= f3_d;
            adr_q           <= adr_d;
            rs2_q           <= rs2_d;
            rd_q            <= rd_d;
            pc_q            <= pc_d;
            lsu_valid_q     <= lsu_valid_d;
            lsu_data_q      <= lsu_data_d;
            lsu_rslt_q      <= lsu_rslt_d;
            lsu_rd_adr_q    <= lsu_rd_adr_d;
            lsu_opcode_q    <= lsu_opcode_d;
            lsu_PC_q        <= lsu_PC_d;
            lsu_exc_q       <= lsu_exc_d;
            lsu_exc_cause_q <= lsu_exc_cause_d;
        end
    end

    assign lsu_valid     = lsu_valid_q;
    assign lsu_data      = lsu_data_q;
    assign lsu_rslt      = lsu_rslt_q;
    assign lsu_rd_adr    = lsu_rd_adr_q;
    assign lsu_opcode    = lsu_opcode_q;
    assign lsu_PC        = lsu_PC_q;
    assign lsu_exc       = lsu_exc_q;
    assign lsu_exc_cause = lsu_exc_cause_q;
endmodule
